fir_sample_ctrl: RTL and testbench
==================================

// Module: fir_sample_ctrl
// PURPOSE
//  Upstream controller for the 4096x16 paged sample memory of the FIR datapath.
//  - Accepts input samples over a valid/ready handshake.
//  - Writes each sample into a circular history buffer held in that memory.
//  - Then reads back the NTAPS most recent samples, newest first, as a tap stream for the MAC stage.
//  - Sole driver of the memory's address, data_in and write_enable_n; consumes its data_out.
// PARAMETERS
//  ADDR_W     12      memory address width
//  DATA_W     16      sample width
//  DEPTH      256     history buffer entries; power of 2, <= 2**ADDR_W
//  NTAPS      32      taps read per sample; 1 <= NTAPS <= DEPTH
//  BASE_ADDR  12'h000 buffer base address; aligned to DEPTH
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst_n      in   1       synchronous reset, active low
//  in_valid   in   1       input sample valid
//  in_data    in   DATA_W  input sample
//  in_ready   out  1       controller idle, can accept a sample
//  flush      in   1       synchronous clear of history state
//  mem_addr   out  ADDR_W  memory address (registered)
//  mem_din    out  DATA_W  memory write data (registered)
//  mem_wen_n  out  1       memory write enable, active low (registered)
//  mem_dout   in   DATA_W  memory read data; valid 1 cycle after its address
//  tap_valid  out  1       tap_data valid this cycle; no backpressure
//  tap_data   out  DATA_W  tap sample
//  tap_idx    out  log2(NTAPS)+1  tap index; 0 = newest
//  tap_last   out  1       final tap of the current sample
//  busy       out  1       sequence in progress (state != IDLE)
// BEHAVIOUR
//  Reset (rst_n=0 at an edge) applies in any state and aborts any sequence:
//   - state=IDLE, wr_ptr=0, fill=0.
//   - mem_addr=0, mem_din=0, mem_wen_n=1, tap_valid=0, tap_idx=0, tap_last=0.
//   - in_ready=0 while rst_n=0.
//  FSM states: IDLE -> WRITE -> READ -> DRAIN -> IDLE. in_ready = (state==IDLE).
//  Accept edge T: in_valid & in_ready. Sample is captured; state -> WRITE.
//  Cycle T+1 (WRITE):
//   - mem_addr=BASE_ADDR|wr_ptr, mem_din=sample, mem_wen_n=0.
//   - newest <= wr_ptr; wr_ptr <= (wr_ptr+1) mod DEPTH; fill <= min(fill+1, NTAPS).
//  Cycles T+2..T+NTAPS+1 (READ):
//   - mem_wen_n=1.
//   - Read k (k=0..NTAPS-1) uses mem_addr=BASE_ADDR|((newest-k) mod DEPTH).
//  DRAIN lasts one cycle: captures the last read; state returns to IDLE at T+NTAPS+3.
//  Tap output:
//   - tap_valid=1 on T+3..T+NTAPS+2.
//   - tap_idx=k, registered along with each read issue.
//   - tap_data = mem_dout, combinational with masking; tap_last=1 only when k=NTAPS-1.
//  Min sample interval: NTAPS+3 cycles. in_valid held high is accepted every NTAPS+3 cycles.
//  A read of the address written the previous cycle returns the new sample.
//  Wrap-around: pointer arithmetic is modulo DEPTH. Addresses never leave [BASE_ADDR, BASE_ADDR+DEPTH-1].
//  flush (rst_n=1) is honoured in any state:
//   - Takes effect like reset, but only on the controller state (wr_ptr=0, fill=0, state=IDLE).
//   - Memory contents are not cleared.
//   - tap_valid=0 the next cycle; no tap_last is issued for an aborted sample.
//  in_valid & flush in the same cycle: flush wins; the sample is not accepted.
//  Pointer and fill arithmetic is unsigned. fill saturates at NTAPS.
// CONFIGURATION
//  FIR_SAMPLE_CTRL_ZERO_FILL_EN
//   - Defined: tap_data forced to 0 when tap_idx >= fill. Startup and post-flush history reads as zeros.
//   - Undefined: tap_data = mem_dout unconditionally; stale memory contents are visible. Fewer gates.
// TESTING
//  (benches: DEPTH=8, NTAPS=4, BASE_ADDR=0, behavioural 1-cycle sync memory model)
//  1 Reset, then sample 16'h1234 accepted at T:
//    write addr 0 at T+1; reads addrs 0,7,6,5; taps 1234,0,0,0 with _EN;
//    tap_last at T+6; in_ready at T+7.
//  2 Stream samples 1..10: 10th written at addr 1; reads addrs 1,0,7,6; taps 10,9,8,7 (wrap).
//  3 in_valid held high, data incrementing: in_ready pulses every 7 cycles;
//    no sample lost or duplicated; mem_wen_n low exactly once per sample.
//  4 flush during READ of sample 5:
//    tap_valid=0 next cycle, no tap_last; next sample 0xAAAA writes addr 0;
//    taps AAAA,0,0,0 with _EN, stale data without _EN.
//  5 rst_n low for 1 cycle mid-READ:
//    all outputs at reset values next cycle; next sample written at addr 0; fill restarts.
//  6 in_valid & flush same cycle: sample dropped; in_ready stays 1; no memory write.

Source files
------------

// File: rtl/fir_sample_ctrl.sv
// Sample-memory controller for the FIR datapath: writes each accepted sample into a
// circular history buffer, then streams the NTAPS newest samples back as taps.
// Optional build macro FIR_SAMPLE_CTRL_ZERO_FILL_EN masks taps older than the known history.
module fir_sample_ctrl #(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 16,
  parameter int                DEPTH     = 256,
  parameter int                NTAPS     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int               IDX_W     = $clog2(NTAPS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wen_n,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_data,
  output logic [IDX_W-1:0]  tap_idx,
  output logic              tap_last,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(NTAPS - 1);
  localparam logic [IDX_W-1:0] FILL_MAX = IDX_W'(NTAPS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] sample;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  fill;
  logic [IDX_W-1:0]  rd_k;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_vld;
  logic              rd_last;

  assign in_ready = rst_n && (state == S_IDLE);
  assign busy     = (state != S_IDLE);

`ifdef FIR_SAMPLE_CTRL_ZERO_FILL_EN
  // Taps beyond the samples seen since reset/flush read as zero, hiding stale memory.
  assign tap_data = (tap_idx >= fill) ? '0 : mem_dout;
`else
  assign tap_data = mem_dout;
`endif

  // NOTE: every register here is updated with <= so all of them see pre-edge values;
  // a blocking update would let later statements observe the new state mid-edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sample    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      rd_k      <= '0;
      rd_idx    <= '0;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_wen_n <= 1'b1;
      tap_valid <= 1'b0;
      tap_idx   <= '0;
      tap_last  <= 1'b0;
    end else if (flush) begin
      // Controller state only; memory contents and the address/data bus are left alone.
      state     <= S_IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
      mem_wen_n <= 1'b1;
      tap_valid <= 1'b0;
      tap_last  <= 1'b0;
    end else begin
      // Tap flags trail the read issue by one cycle to line up with mem_dout.
      tap_valid <= rd_vld;
      tap_idx   <= rd_idx;
      tap_last  <= rd_last;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sample <= in_data;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          mem_addr  <= BASE_ADDR | ADDR_W'(wr_ptr);
          mem_din   <= sample;
          mem_wen_n <= 1'b0;
          rd_ptr    <= wr_ptr;
          wr_ptr    <= (wr_ptr + PTR_W'(1)) & PTR_MASK;
          fill      <= (fill < FILL_MAX) ? fill + IDX_W'(1) : fill;
          rd_k      <= '0;
          state     <= S_READ;
        end
        S_READ: begin
          mem_addr  <= BASE_ADDR | ADDR_W'(rd_ptr);
          mem_wen_n <= 1'b1;
          rd_ptr    <= (rd_ptr - PTR_W'(1)) & PTR_MASK;
          rd_vld    <= 1'b1;
          rd_idx    <= rd_k;
          rd_last   <= (rd_k == LAST_K);
          rd_k      <= rd_k + IDX_W'(1);
          if (rd_k == LAST_K) state <= S_DRAIN;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_ctrl.sv
// Scoreboard bench for fir_sample_ctrl (DEPTH=8, NTAPS=4) against a 1-cycle synchronous
// memory model; expected writes and taps come from a history-array reference model.
module tb_fir_sample_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int NTAPS  = 4;
  localparam int IDX_W  = $clog2(NTAPS) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_wen_n;
  logic [DATA_W-1:0] mem_dout;
  logic              tap_valid;
  logic [DATA_W-1:0] tap_data;
  logic [IDX_W-1:0]  tap_idx;
  logic              tap_last;
  logic              busy;

  fir_sample_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NTAPS(NTAPS), .BASE_ADDR(12'h000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen_n(mem_wen_n),
    .mem_dout(mem_dout), .tap_valid(tap_valid), .tap_data(tap_data), .tap_idx(tap_idx),
    .tap_last(tap_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory with preloaded, recognisable contents.
  logic [DATA_W-1:0] mem [4096];
  initial for (int i = 0; i < 4096; i++) mem[i] = 16'hC000 | 16'(i);
  always @(posedge clk) begin
    if (!mem_wen_n) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  typedef struct { logic [DATA_W-1:0] d; int idx; logic last; } tap_t;
  typedef struct { int a; logic [DATA_W-1:0] d; } wr_t;
  tap_t tq[$];
  wr_t  wq[$];

  // Reference model: what the buffer holds, where the next sample goes, how many are known.
  logic [DATA_W-1:0] hist [DEPTH];
  int m_wr = 0;
  int m_fill = 0;
  int n_acc = 0;
  int n_wr = 0;
  int n_cmp = 0;
  int n_bad = 0;

  initial for (int i = 0; i < DEPTH; i++) hist[i] = 16'hC000 + 16'(i);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_accept(input logic [DATA_W-1:0] d);
    wr_t w;
    tap_t t;
    w.a = m_wr;
    w.d = d;
    wq.push_back(w);
    hist[m_wr] = d;
    m_fill = (m_fill + 1 > NTAPS) ? NTAPS : m_fill + 1;
    for (int k = 0; k < NTAPS; k++) begin
      t.idx  = k;
      t.last = (k == NTAPS - 1);
`ifdef FIR_SAMPLE_CTRL_ZERO_FILL_EN
      t.d = (k >= m_fill) ? '0 : hist[(m_wr - k + DEPTH) % DEPTH];
`else
      t.d = hist[(m_wr - k + DEPTH) % DEPTH];
`endif
      tq.push_back(t);
    end
    m_wr = (m_wr + 1) % DEPTH;
    n_acc++;
  endtask

  task automatic model_clear();
    m_wr = 0;
    m_fill = 0;
    tq.delete();
  endtask

  // Monitors: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst_n && tap_valid) begin
      if (tq.size() == 0) begin
        check("unexpected_tap", 32'(tap_idx), 32'hFFFF_FFFF);
      end else begin
        tap_t e;
        e = tq.pop_front();
        check("tap_data", 32'(tap_data), 32'(e.d));
        check("tap_idx", 32'(tap_idx), 32'(e.idx));
        check("tap_last", 32'(tap_last), 32'(e.last));
      end
    end
    if (rst_n && !mem_wen_n) begin
      n_wr++;
      if (wq.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.a));
        check("wr_data", 32'(mem_din), 32'(w.d));
      end
    end
  end

  // Offers a sample at the falling edge and waits (bounded) for in_ready; in_valid stays high.
  task automatic send(input logic [DATA_W-1:0] d, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = -1;
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      model_accept(d);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((tq.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(tq.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"}, 32'(mem_din), 32'd0);
    check({tag, "_mem_wen_n"}, 32'(mem_wen_n), 32'd1);
    check({tag, "_tap_valid"}, 32'(tap_valid), 32'd0);
    check({tag, "_tap_idx"}, 32'(tap_idx), 32'd0);
    check({tag, "_tap_last"}, 32'(tap_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0;
    int t1;
    int acc [$];
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // First sample after reset, with exact latency of the last tap and the next ready.
    send(16'h1234, t0);
    drop_valid();
    t1 = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tap_last && t1 < 0) t1 = cyc;
    end
    check("tap_last_latency", 32'(t1 - t0), 32'd6);
    check("ready_after_seq", 32'(in_ready), 32'd1);

    // Ten samples from reset: wraps the pointer past the end of the buffer.
    do_reset();
    for (int i = 1; i <= 10; i++) send(16'(i), t0);
    drop_valid();
    wait_drain();

    // in_valid held high: one accept every NTAPS+3 cycles.
    for (int i = 0; i < 5; i++) begin
      send(16'h5000 + 16'(i), t0);
      acc.push_back(t0);
    end
    drop_valid();
    for (int i = 1; i < 5; i++) check("accept_spacing", 32'(acc[i] - acc[i-1]), 32'd7);
    wait_drain();

    // Flush during the read phase of the fifth sample since reset.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send(16'h0100 + 16'(i), t0);
      if (i < 5) drop_valid();
    end
    drop_valid();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    flush = 1'b0;
    @(posedge clk);
    #1;
    check("flush_tap_valid", 32'(tap_valid), 32'd0);
    check("flush_tap_last", 32'(tap_last), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    send(16'hAAAA, t0);
    drop_valid();
    wait_drain();

    // Reset pulse in the middle of a read sequence.
    send(16'h7777, t0);
    drop_valid();
    repeat (3) @(posedge clk);
    do_reset();
    send(16'h4242, t0);
    drop_valid();
    wait_drain();

    // in_valid together with flush: the sample is dropped and nothing is written.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    check("flush_drop_busy", 32'(busy), 32'd0);
    check("flush_drop_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (4) @(negedge clk);
    send(16'hBEEF, t0);
    drop_valid();
    wait_drain();

    // Randomised traffic with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), t0);
      if ($urandom_range(0, 1) == 1) begin
        drop_valid();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drop_valid();
    wait_drain();

    repeat (4) @(negedge clk);
    check("tap_queue_empty", 32'(tq.size()), 32'd0);
    check("write_queue_empty", 32'(wq.size()), 32'd0);
    check("one_write_per_sample", 32'(n_wr), 32'(n_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
